// File: rtl/bsg_piso_tx_pkg.sv
// Shared types and beat-count helper for the bsg_piso_tx transmitter.
// Optional parity beat selected by macro BSG_PISO_TX_PARITY_EN.
package bsg_piso_tx_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } bsg_piso_tx_state_e;

   // Beats emitted per accepted word, including the parity beat when enabled.
   function automatic int bsg_piso_tx_beats(input int els_p);
`ifdef BSG_PISO_TX_PARITY_EN
      return els_p + 32'sd1;
`else
      return els_p;
`endif
   endfunction

endpackage

// File: rtl/bsg_piso_tx_chk.sv
// Protocol checker for bsg_piso_tx: the consumer may only take a beat that is valid.
// Parity configuration (BSG_PISO_TX_PARITY_EN) does not affect this rule.
module bsg_piso_tx_chk (
   input logic clk_i,
   input logic reset_i,
   input logic valid_o,
   input logic yumi_i
);

   yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> valid_o)
      else $error("bsg_piso_tx: yumi_i asserted while valid_o is low");

endmodule

// File: rtl/bsg_piso_tx_ctr.sv
// Beat counter for bsg_piso_tx: clear on word accept, increment per consumed beat,
// saturating at the last beat and flagging it. Parity beat via BSG_PISO_TX_PARITY_EN.
module bsg_piso_tx_ctr
   import bsg_piso_tx_pkg::*;
#(
   parameter int els_p = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic incr_i,
   output logic last_o
);

   localparam int cnt_w_lp = $clog2(els_p + 1);
   localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(bsg_piso_tx_beats(els_p) - 1);
   localparam logic [cnt_w_lp-1:0] one_lp = cnt_w_lp'(1);

   logic [cnt_w_lp-1:0] beat_cnt_r;
   logic                last_s;

   assign last_s = (beat_cnt_r == last_beat_lp);
   assign last_o = last_s;

   // Counter never advances past the last beat; a new word restarts it at zero.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         beat_cnt_r <= '0;
      end else if (clear_i) begin
         beat_cnt_r <= '0;
      end else if (incr_i && !last_s) begin
         beat_cnt_r <= beat_cnt_r + one_lp;
      end else begin
         beat_cnt_r <= beat_cnt_r;
      end
   end

endmodule

// File: rtl/bsg_piso_tx.sv
// Parallel-in serial-out transmitter: one width_p*els_p word in, els_p beats out, LSB slice first.
// Define BSG_PISO_TX_PARITY_EN to append a parity beat (bit 0 = XOR of the word).
module bsg_piso_tx
   import bsg_piso_tx_pkg::*;
#(
   parameter int width_p = 4,
   parameter int els_p   = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       valid_i,
   input  logic [width_p*els_p-1:0]   data_i,
   output logic                       ready_and_o,
   output logic                       valid_o,
   output logic [width_p-1:0]         data_o,
   input  logic                       yumi_i
);

   localparam int beats_lp = bsg_piso_tx_beats(els_p);
   localparam int sr_w_lp  = width_p * beats_lp;

   function automatic logic word_parity(input logic [width_p*els_p-1:0] word);
      return ^word;
   endfunction

   bsg_piso_tx_state_e     state_r;
   bsg_piso_tx_state_e     state_n_s;
   logic [sr_w_lp-1:0]     shift_r;
   logic [sr_w_lp-1:0]     load_s;
   logic                   accept_s;
   logic                   advance_s;
   logic                   last_s;
   logic                   ready_s;

   // Ready only ever looks at state and yumi_i, so a word can land on the last beat's edge.
   assign ready_s     = (state_r == IDLE) | ((state_r == SEND) & last_s & yumi_i);
   assign ready_and_o = ready_s;
   assign accept_s    = valid_i & ready_s;
   assign advance_s   = (state_r == SEND) & yumi_i;

   assign valid_o = (state_r == SEND);
   assign data_o  = shift_r[width_p-1:0];

   // Image loaded into the shift register; the parity slice rides above the data slices.
`ifdef BSG_PISO_TX_PARITY_EN
   logic [width_p-1:0] par_beat_s;
   always_comb begin
      par_beat_s    = '0;
      par_beat_s[0] = word_parity(data_i);
      load_s        = {par_beat_s, data_i};
   end
`else
   always_comb begin
      load_s = sr_w_lp'(data_i);
   end
`endif

   // Next-state decode: a fresh word always wins, otherwise the last consumed beat drops to IDLE.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_n_s = SEND;
            end else begin
               state_n_s = IDLE;
            end
         end
         SEND: begin
            if (accept_s) begin
               state_n_s = SEND;
            end else if (advance_s && last_s) begin
               state_n_s = IDLE;
            end else begin
               state_n_s = SEND;
            end
         end
         default: begin
            state_n_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Shift register: load on accept, drop the consumed low slice on each yumi.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         shift_r <= '0;
      end else if (accept_s) begin
         shift_r <= load_s;
      end else if (advance_s) begin
         shift_r <= shift_r >> width_p;
      end else begin
         shift_r <= shift_r;
      end
   end

   bsg_piso_tx_ctr #(
      .els_p (els_p)
   ) ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (accept_s),
      .incr_i  (advance_s),
      .last_o  (last_s)
   );

   bsg_piso_tx_chk chk (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .valid_o (valid_o),
      .yumi_i  (yumi_i)
   );

endmodule

// File: doc/bsg_piso_tx.md
# bsg_piso_tx

Parallel-in, serial-out transmitter.
- Accepts one `width_p*els_p`-bit word over a ready/valid handshake.
- Emits it as `els_p` beats of `width_p` bits over a valid/yumi handshake.
- Sits on the outbound side of narrow links, as the transmit counterpart of the word-wide bitwise datapath cells (`bsg_nor2` and similar) that produce the words.
- Beats go out LSB-slice first, with full throughput on back-to-back words.

## Interface
Parameters:
- `width_p`, default 4: beat width in bits.
- `els_p`, default 4: beats per word; must be ≥ 2.

Ports:
- `clk_i`, in, 1: the single clock.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `valid_i`, in, 1: input word valid.
- `data_i`, in, `width_p*els_p`: input word.
- `ready_and_o`, out, 1: block can accept a word this cycle.
- `valid_o`, out, 1: output beat valid.
- `data_o`, out, `width_p`: output beat.
- `yumi_i`, in, 1: consumer takes the beat. Legal only when `valid_o` = 1.

## Operation
- States (`IDLE`, `SEND`):
  - `IDLE`: `ready_and_o` = 1, `valid_o` = 0.
  - `SEND`: `valid_o` = 1; `data_o` = current low slice of the shift register.
- Word accept: a word is accepted on any edge where `valid_i & ready_and_o`.
  - The word loads into the shift register.
  - `beat_cnt_r` clears to 0.
  - State goes to `SEND`.
- Beat advance: on each edge with `yumi_i` in `SEND`:
  - The shift register shifts right by `width_p`.
  - `beat_cnt_r` increments.
- Last beat (`beat_cnt_r` = `last_beat`):
  - `ready_and_o` = 1 combinationally iff `yumi_i` = 1.
  - If a word is accepted on that same edge: it reloads, and the block stays in `SEND` with no bubble.
  - Otherwise: state goes to `IDLE`.
- Ready rule: `ready_and_o` = (`IDLE`) | (`SEND` & last beat & `yumi_i`). It never depends on `valid_i`.
- Beat order: beat *k* = `data_i[k*width_p +: width_p]`.
- Counter: `beat_cnt_r` is `$clog2(els_p+1)` bits wide and never wraps past `last_beat`.
- Protocol violation: `yumi_i` = 1 while `valid_o` = 0 is illegal. Simulation assertion fires; RTL behaviour for this case is undefined.
- Reset values: state `IDLE`, `valid_o` = 0, `data_o` = 0, `ready_and_o` = 1, `beat_cnt_r` = 0.
- Reset mid-word: the remaining beats are dropped, and `valid_o` falls asynchronously with `reset_i`.

## Timing
- Latency: word accepted at edge *n* → beat 0 valid in the cycle after edge *n*.
- Beat hold: each beat is held stable until its `yumi_i` edge.
- Throughput: with `yumi_i` held high and words back-to-back, one word every `els_p` cycles (`els_p+1` with parity).
- Outputs: `data_o` and `valid_o` come from registers. `ready_and_o` is the only output with a combinational path, from `yumi_i`.
- Reset release: the first word is accepted on the first edge after `reset_i` deasserts.

## Configuration
Macro: `BSG_PISO_TX_PARITY_EN`.
- Defined:
  - One extra parity beat follows the data beats, so `last_beat` = `els_p`.
  - Parity beat: bit 0 = XOR-reduce of the accepted word; upper bits 0.
  - The parity value is captured at word accept.
- Undefined:
  - `last_beat` = `els_p-1`.
  - No parity register; no extra beat.

## Structure
- Package `bsg_piso_tx_pkg` holds:
  - `typedef enum logic [0:0] {IDLE, SEND} bsg_piso_tx_state_e`.
  - Function `bsg_piso_tx_beats(els_p)`, which returns the beat count with or without parity.
- Sub-module `bsg_piso_tx_ctr`: beat counter with clear, increment and last-beat flag.
  - Instantiated once.
  - Async active-high reset on `clk_i` / `reset_i`.

## Test plan
All cases use defaults `width_p`=4, `els_p`=4.
- Single word: `data_i`=0xA5C3, `yumi_i` held high → beats 0x3, 0xC, 0x5, 0xA on 4 consecutive cycles starting the cycle after accept, then `valid_o`=0.
  - With `BSG_PISO_TX_PARITY_EN`: a 5th beat 0x0 follows.
- Back-to-back: 0x1234 then 0xFFFF offered continuously, `yumi_i` high → 8 contiguous beats 4,3,2,1,F,F,F,F.
  - `ready_and_o` high on the 4th beat's cycle.
  - No idle cycle between words.
- Backpressure: 0x00F0 with `yumi_i` low for 3 cycles at beat 1 → `data_o` holds 0xF and `valid_o` holds 1 for those 3 cycles.
  - `ready_and_o`=0 throughout.
  - Sequence resumes 0x0, 0x0 afterwards.
- Parity (macro defined): 0x0001 → 5th beat 0x1; 0x0003 → 5th beat 0x0.
- Reset mid-word: assert `reset_i` after beat 1 of 0xBEEF, asynchronously between edges → `valid_o`=0 immediately.
  - After release, `ready_and_o`=1.
  - Next word 0x0042 emits 2,4,0,0 with no residue of 0xBEEF.
- Idle input: `valid_i`=0 for 10 cycles → `valid_o` stays 0 and `ready_and_o` stays 1.
